cell_scan_controller: RTL and testbench
=======================================

Name: cell_scan_controller

Overview:
- Sequences one image frame through the combinational cell processor.
- Walks the centre-pixel position in raster order and requests cell windows (cellA, plus cellB for two-operand ops) from the cell-fetch unit.
- Drives the processor's opcode and user input, captures processedCell and hands each result to the result writer.
- Sits between the frame buffer / cell-fetch logic and the cell processor.

Parameters:
IMG_W, 64, image width in pixels (>=3)
IMG_H, 64, image height in pixels (>=3)
PIXEL_W, 8, pixel width; matches the package pixel_t
COL_W, $clog2(IMG_W), column index width (derived)
ROW_W, $clog2(IMG_H), row index width (derived)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin frame; sampled only in IDLE
abort  in  1  cancel frame; return to IDLE
cfg_opcode  in  opcode_t  operation for the frame
cfg_userInput  in  PIXEL_W  immediate operand for ADDI/SUBI
busy  out  1  frame in progress
done  out  1  one-cycle pulse, frame complete
fetch_req  out  1  cell fetch request
fetch_sel  out  1  0 = load cellA, 1 = load cellB
fetch_row  out  ROW_W  centre-pixel row
fetch_col  out  COL_W  centre-pixel column
fetch_ack  in  1  requested cell is loaded into the processor input
proc_opcode  out  opcode_t  to processor opcode
proc_userInput  out  PIXEL_W  to processor userInputA
proc_result  in  PIXEL_W  from processor processedCell
wr_valid  out  1  result valid
wr_ready  in  1  writer accepts
wr_row  out  ROW_W  result row
wr_col  out  COL_W  result column
wr_data  out  PIXEL_W  result pixel

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; row = 0, col = 0.
  - All outputs 0, proc_opcode included, except: wr_data = 0, proc_userInput = 0.
- States: IDLE, FETCH_A, FETCH_B, EXEC, WRITE, DONE.
- IDLE:
  - start=1 latches cfg_opcode and cfg_userInput into the frame config and clears row/col.
  - Next state is FETCH_A.
  - Config is held constant for the whole frame; start is ignored outside IDLE.
- need_b = (opcode == ADD or opcode == SUB).
- FETCH_A:
  - fetch_req=1, fetch_sel=0. fetch_req is held until fetch_ack.
  - Ack in the same cycle as req completes the fetch.
  - On ack: go to FETCH_B if need_b, else EXEC.
- FETCH_B: same as FETCH_A with fetch_sel=1; on ack go to EXEC.
- EXEC (one cycle): register proc_result into wr_data, go to WRITE.
- WRITE:
  - wr_valid=1 with wr_row/wr_col/wr_data stable until wr_ready.
  - On wr_ready: advance col; at col == IMG_W-1, wrap col to 0 and increment row.
  - After the last pixel (IMG_H-1, IMG_W-1) go to DONE; otherwise go to FETCH_A.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- proc_opcode and proc_userInput are driven from the latched config in all non-IDLE states; 0 in IDLE.
- Minimum per-pixel cost (ack and ready always high): 3 cycles, or 4 with need_b.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; done is not pulsed.
  - fetch_req and wr_valid drop on the next edge.
  - abort has priority over ack/ready in the same cycle.
- Unknown opcode: no cellB fetch. The processor passes the centre pixel through, and the controller writes it normally.
- Counters never exceed IMG_W-1 / IMG_H-1.

Optional Feature:
- Macro: CELL_SCAN_BORDER_SKIP_EN.
- Defined:
  - Scan covers only rows 1..IMG_H-2 and cols 1..IMG_W-2.
  - Start position is (1,1); col wraps from IMG_W-2 to 1.
  - Frame yields (IMG_H-2)*(IMG_W-2) writes; border pixels are never fetched or written.
- Undefined: full IMG_H*IMG_W scan as above.

Test Plan:
- IMG_W=4, IMG_H=3, ADDI, userInput=5, ack/ready tied 1, start pulse:
  - 12 writes in raster order (0,0)..(2,3).
  - wr_data equals proc_result at each EXEC.
  - busy high 37 cycles (36 + DONE); single done pulse.
- ADD frame: every pixel issues fetch_sel=0 then fetch_sel=1 requests; 4 cycles/pixel; 12 writes.
  - SUB frame: the same pattern holds.
- Backpressure: fetch_ack delayed 3 cycles, wr_ready low 2 cycles at pixel (1,2):
  - fetch_req and wr_valid held steady with stable address/data.
  - No pixel skipped or duplicated.
- abort asserted during WRITE of (1,1) with wr_ready=1 the same cycle:
  - IDLE next cycle; no done; no further wr_valid.
  - A new start restarts from (0,0).
- rst_n dropped mid-frame in FETCH_B: outputs 0 immediately (asynchronous), state IDLE; start ignored while rst_n low.
- With CELL_SCAN_BORDER_SKIP_EN, 4x3 image: exactly 2 writes at (1,1) and (1,2), then done.

Source files
------------

// File: rtl/cell_scan_pkg.sv
// Shared pixel/opcode types for the cell-processing pipeline.
// Opcode encodings match the combinational cell processor.
package cell_scan_pkg;
  typedef logic [7:0] pixel_t;
  typedef logic [3:0] opcode_t;
  localparam opcode_t OP_ADD  = 4'd0;
  localparam opcode_t OP_SUB  = 4'd1;
  localparam opcode_t OP_ADDI = 4'd2;
  localparam opcode_t OP_SUBI = 4'd3;
endpackage

// File: rtl/cell_scan_controller.sv
// Raster-order frame sequencer for the cell processor.
// Optional: CELL_SCAN_BORDER_SKIP_EN restricts the scan to interior pixels.
module cell_scan_controller
  import cell_scan_pkg::*;
#(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int PIXEL_W = 8,
  parameter int COL_W   = $clog2(IMG_W),
  parameter int ROW_W   = $clog2(IMG_H)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  opcode_t            cfg_opcode,
  input  logic [PIXEL_W-1:0] cfg_userInput,
  output logic               busy,
  output logic               done,
  output logic               fetch_req,
  output logic               fetch_sel,
  output logic [ROW_W-1:0]   fetch_row,
  output logic [COL_W-1:0]   fetch_col,
  input  logic               fetch_ack,
  output opcode_t            proc_opcode,
  output logic [PIXEL_W-1:0] proc_userInput,
  input  logic [PIXEL_W-1:0] proc_result,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [ROW_W-1:0]   wr_row,
  output logic [COL_W-1:0]   wr_col,
  output logic [PIXEL_W-1:0] wr_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FA    = 3'd1;
  localparam logic [2:0] S_FB    = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

`ifdef CELL_SCAN_BORDER_SKIP_EN
  localparam int C_FIRST = 1;
  localparam int C_LAST  = IMG_W - 2;
  localparam int R_FIRST = 1;
  localparam int R_LAST  = IMG_H - 2;
`else
  localparam int C_FIRST = 0;
  localparam int C_LAST  = IMG_W - 1;
  localparam int R_FIRST = 0;
  localparam int R_LAST  = IMG_H - 1;
`endif

  localparam logic [COL_W-1:0] COL0 = COL_W'(C_FIRST);
  localparam logic [COL_W-1:0] COLN = COL_W'(C_LAST);
  localparam logic [ROW_W-1:0] ROW0 = ROW_W'(R_FIRST);
  localparam logic [ROW_W-1:0] ROWN = ROW_W'(R_LAST);

  logic [2:0]         r_state;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  opcode_t            r_op;
  logic [PIXEL_W-1:0] r_ui;
  logic [PIXEL_W-1:0] r_wdata;

  logic w_need_b;
  logic w_col_last;
  logic w_row_last;
  logic w_active;

  assign w_need_b   = (r_op == OP_ADD) || (r_op == OP_SUB);
  assign w_col_last = (r_col == COLN);
  assign w_row_last = (r_row == ROWN);
  assign w_active   = (r_state != S_IDLE);

  // Frame FSM, position counters, latched config and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_op    <= '0;
      r_ui    <= '0;
      r_wdata <= '0;
    end else if (abort && w_active) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= cfg_opcode;
            r_ui    <= cfg_userInput;
            r_row   <= ROW0;
            r_col   <= COL0;
            r_state <= S_FA;
          end
        end
        S_FA: begin
          if (fetch_ack) begin
            r_state <= w_need_b ? S_FB : S_EXEC;
          end
        end
        S_FB: begin
          if (fetch_ack) begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_wdata <= proc_result;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (wr_ready) begin
            if (w_col_last) begin
              r_col <= COL0;
              if (w_row_last) begin
                r_state <= S_DONE;
              end else begin
                r_row   <= r_row + ROW_W'(1);
                r_state <= S_FA;
              end
            end else begin
              r_col   <= r_col + COL_W'(1);
              r_state <= S_FA;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = w_active;
  assign done           = (r_state == S_DONE);
  assign fetch_req      = (r_state == S_FA) || (r_state == S_FB);
  assign fetch_sel      = (r_state == S_FB);
  assign fetch_row      = r_row;
  assign fetch_col      = r_col;
  assign proc_opcode    = w_active ? r_op : '0;
  assign proc_userInput = w_active ? r_ui : '0;
  assign wr_valid       = (r_state == S_WRITE);
  assign wr_row         = r_row;
  assign wr_col         = r_col;
  assign wr_data        = r_wdata;

endmodule

// File: tb/tb_cell_scan_controller.sv
// Directed bench for cell_scan_controller on a 4x3 image.
// Processor model: result = {row,col} nibbles + userInput.
module tb_cell_scan_controller;
  import cell_scan_pkg::*;

  localparam int W = 4;
  localparam int H = 3;
`ifdef CELL_SCAN_BORDER_SKIP_EN
  localparam int C0 = 1;
  localparam int C1 = W - 2;
  localparam int R0 = 1;
  localparam int R1 = H - 2;
`else
  localparam int C0 = 0;
  localparam int C1 = W - 1;
  localparam int R0 = 0;
  localparam int R1 = H - 1;
`endif
  localparam int NPIX = (C1 - C0 + 1) * (R1 - R0 + 1);

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  opcode_t    cfg_opcode;
  logic [7:0] cfg_userInput;
  logic       busy;
  logic       done;
  logic       fetch_req;
  logic       fetch_sel;
  logic [1:0] fetch_row;
  logic [1:0] fetch_col;
  logic       fetch_ack;
  opcode_t    proc_opcode;
  logic [7:0] proc_userInput;
  logic [7:0] proc_result;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_row;
  logic [1:0] wr_col;
  logic [7:0] wr_data;

  int tests = 0;
  int fails = 0;

  cell_scan_controller #(.IMG_W(W), .IMG_H(H), .PIXEL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_opcode(cfg_opcode), .cfg_userInput(cfg_userInput),
    .busy(busy), .done(done),
    .fetch_req(fetch_req), .fetch_sel(fetch_sel),
    .fetch_row(fetch_row), .fetch_col(fetch_col),
    .fetch_ack(fetch_ack),
    .proc_opcode(proc_opcode), .proc_userInput(proc_userInput),
    .proc_result(proc_result),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data)
  );

  assign proc_result =
    {2'b00, fetch_row, 2'b00, fetch_col} + proc_userInput;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input opcode_t op,
                           input logic [7:0] ui,
                           input bit bp,
                           input int cpp,
                           input bit nb);
    int busy_n = 0;
    int done_n = 0;
    int wr_n   = 0;
    int a_n    = 0;
    int b_n    = 0;
    int cyc    = 0;
    int fst    = 0;
    int wst    = 0;
    int er     = R0;
    int ec     = C0;
    bit a_pend = 0;
    logic [1:0] ar, ac;
    bit pf = 0;
    bit pw = 0;
    logic       ps;
    logic [1:0] pr, pc, qr, qc;
    logic [7:0] pd;
    int exp_busy;
    exp_busy = NPIX * cpp + 1 + (bp ? 5 : 0);
    @(negedge clk);
    cfg_opcode    = op;
    cfg_userInput = ui;
    start         = 1'b1;
    fetch_ack     = 1'b1;
    wr_ready      = 1'b1;
    @(negedge clk);
    start         = 1'b0;
    cfg_opcode    = ~op;
    cfg_userInput = ~ui;
    while (cyc < 2000) begin
      if (busy) begin
        busy_n++;
        if (proc_opcode !== op || proc_userInput !== ui)
          chk("cfg_hold", {proc_opcode, proc_userInput}, {op, ui});
      end
      if (done) done_n++;
      fetch_ack = 1'b1;
      if (bp && fetch_req && fetch_row == 2'd1 && fetch_col == 2'd2) begin
        fetch_ack = (fst >= 3);
        fst = fetch_ack ? 0 : fst + 1;
      end
      wr_ready = 1'b1;
      if (bp && wr_valid && wr_row == 2'd1 && wr_col == 2'd2) begin
        wr_ready = (wst >= 2);
        wst = wr_ready ? 0 : wst + 1;
      end
      if (pf)
        chk("fetch_hold", {fetch_req, fetch_sel, fetch_row, fetch_col},
            {1'b1, ps, pr, pc});
      if (pw)
        chk("wr_hold", {wr_valid, wr_row, wr_col, wr_data},
            {1'b1, qr, qc, pd});
      if (fetch_req && fetch_ack) begin
        if (!fetch_sel) begin
          a_n++;
          a_pend = 1;
          ar = fetch_row;
          ac = fetch_col;
        end else begin
          b_n++;
          chk("b_after_a", {a_pend, fetch_row, fetch_col}, {1'b1, ar, ac});
          a_pend = 0;
        end
      end
      if (wr_valid && wr_ready) begin
        chk("wr_pos", {wr_row, wr_col}, {2'(er), 2'(ec)});
        chk("wr_data", wr_data, 8'(er * 16 + ec) + ui);
        wr_n++;
        ec++;
        if (ec > C1) begin
          ec = C0;
          er++;
        end
      end
      pf = fetch_req && !fetch_ack;
      ps = fetch_sel;
      pr = fetch_row;
      pc = fetch_col;
      pw = wr_valid && !wr_ready;
      qr = wr_row;
      qc = wr_col;
      pd = wr_data;
      if (done_n > 0 && !busy) break;
      @(negedge clk);
      cyc++;
    end
    fetch_ack = 1'b1;
    wr_ready  = 1'b1;
    chk("frame_timeout", 32'(cyc < 2000), 1);
    chk("busy_cycles", busy_n, exp_busy);
    chk("done_pulses", done_n, 1);
    chk("writes", wr_n, NPIX);
    chk("fetch_a", a_n, NPIX);
    chk("fetch_b", b_n, nb ? NPIX : 0);
    chk("idle_opcode", {proc_opcode, proc_userInput}, 0);
  endtask

  initial begin
    bit found;
    bit bad;
    rst_n         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    cfg_opcode    = OP_ADD;
    cfg_userInput = 8'd0;
    fetch_ack     = 1'b1;
    wr_ready      = 1'b1;
    #3;
    chk("rst_ctl", {busy, done, fetch_req, fetch_sel, wr_valid}, 0);
    chk("rst_pos", {fetch_row, fetch_col, wr_row, wr_col}, 0);
    chk("rst_data", {proc_opcode, proc_userInput, wr_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(OP_ADDI, 8'd5, 0, 3, 0);
    run_frame(OP_ADD, 8'd0, 0, 4, 1);
    run_frame(OP_SUB, 8'd3, 0, 4, 1);
    run_frame(4'hF, 8'd7, 0, 3, 0);
    run_frame(OP_SUBI, 8'd9, 1, 3, 0);

    // abort in WRITE of (1,1) with wr_ready high
    @(negedge clk);
    cfg_opcode    = OP_ADDI;
    cfg_userInput = 8'd1;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (wr_valid && wr_row == 2'd1 && wr_col == 2'd1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_reach", 32'(found), 1);
    abort    = 1'b1;
    wr_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", {busy, done, wr_valid, fetch_req}, 0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wr_valid || done || busy) bad = 1;
    end
    chk("abort_quiet", 32'(bad), 0);
    run_frame(OP_ADDI, 8'd2, 0, 3, 0);

    // asynchronous reset while in FETCH_B of an interior pixel
    @(negedge clk);
    cfg_opcode    = OP_ADD;
    cfg_userInput = 8'd4;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (fetch_req && fetch_sel && fetch_row == 2'd1 && fetch_col == 2'd1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("fb_reach", 32'(found), 1);
    fetch_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ctl", {busy, fetch_req, fetch_sel, wr_valid, done}, 0);
    chk("arst_out", {fetch_row, fetch_col, proc_opcode, proc_userInput, wr_data}, 0);
    start = 1'b1;
    @(negedge clk);
    chk("rst_start_ign1", busy, 0);
    @(negedge clk);
    chk("rst_start_ign2", busy, 0);
    start     = 1'b0;
    fetch_ack = 1'b1;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {busy, fetch_req}, 0);
    run_frame(OP_ADDI, 8'd5, 0, 3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
